// File: rtl/ps2_pkg.sv
// Shared constants, event type and parity helper for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_CODE_EXT = 8'hE0;
    localparam logic [7:0] PS2_CODE_BRK = 8'hF0;
    localparam logic [7:0] PS2_LSHIFT   = 8'h12;
    localparam logic [7:0] PS2_RSHIFT   = 8'h59;
    localparam logic [7:0] PS2_CTRL     = 8'h14;
    localparam int         FRAME_BITS   = 11;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_evt_t;

    typedef enum logic [1:0] {
        DEC_IDLE = 2'd0,
        DEC_EXT  = 2'd1,
        DEC_BRK  = 2'd2
    } dec_state_t;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line synchroniser and 11-bit frame deserialiser with start/stop/parity checks
// and a mid-frame inactivity timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] data_sync_r;
    logic [3:0]             bit_cnt_r;
    logic [9:0]             shift_r;
    logic [TW-1:0]          idle_cnt_r;
    logic                   frame_err_r;
    logic                   fall_s;
    logic                   bit_s;
    logic                   last_bit_s;
    logic                   frame_ok_s;
    logic                   timeout_s;

    // Lines idle high, so the chains reset to 1 to avoid a phantom falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_r  <= {SYNC_STAGES{1'b1}};
            data_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign fall_s     = clk_sync_r[SYNC_STAGES-1] & ~clk_sync_r[SYNC_STAGES-2];
    assign bit_s      = data_sync_r[SYNC_STAGES-2];
    assign last_bit_s = fall_s && (bit_cnt_r == 4'(FRAME_BITS - 1));
    assign frame_ok_s = !shift_r[0] && bit_s && odd_parity_ok(shift_r[8:1], shift_r[9]);
    assign timeout_s  = (bit_cnt_r != 4'd0) && !fall_s && (idle_cnt_r == TW'(TIMEOUT_CYC - 1));
    assign byte_valid = last_bit_s && frame_ok_s;
    assign rx_byte    = shift_r[8:1];
    assign frame_err  = frame_err_r;

    // Bit counter, shift register and inactivity timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r   <= 4'd0;
            shift_r     <= 10'd0;
            idle_cnt_r  <= '0;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= (last_bit_s && !frame_ok_s) || timeout_s;
            if (fall_s) begin
                shift_r    <= {bit_s, shift_r[9:1]};
                idle_cnt_r <= '0;
                bit_cnt_r  <= last_bit_s ? 4'd0 : bit_cnt_r + 4'd1;
            end else if (timeout_s) begin
                bit_cnt_r  <= 4'd0;
                idle_cnt_r <= '0;
            end else if (bit_cnt_r != 4'd0) begin
                idle_cnt_r <= idle_cnt_r + TW'(1);
            end else begin
                idle_cnt_r <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_rx_fifo.sv
// PS/2 keyboard receiver: frame RX, prefix decoder / modifier tracking and show-ahead
// event FIFO. Define PS2_KBD_DECODE_EN to enable the E0/F0 decoder and modifier tracking.
module ps2_kbd_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    input  logic                        rd_en,
    output logic                        key_valid,
    output logic [9:0]                  key_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    output logic                        frame_err,
    output logic                        shift_held,
    output logic                        ctrl_held
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic       byte_valid_s;
    logic [7:0] rx_byte_s;
    logic       evt_push_s;
    key_evt_t   evt_s;

    ps2_frame_rx #(
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_frame_rx (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(byte_valid_s),
        .rx_byte   (rx_byte_s),
        .frame_err (frame_err)
    );

`ifdef PS2_KBD_DECODE_EN
    dec_state_t state_r;
    dec_state_t state_nxt_s;
    logic       ext_r;
    logic       shift_held_r;
    logic       ctrl_held_r;

    // Decoder state and the extended-prefix flag carried through BRK.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= DEC_IDLE;
            ext_r   <= 1'b0;
        end else if (byte_valid_s) begin
            state_r <= state_nxt_s;
            if (state_nxt_s == DEC_IDLE) begin
                ext_r <= 1'b0;
            end else if (state_nxt_s == DEC_EXT) begin
                ext_r <= 1'b1;
            end else begin
                ext_r <= ext_r;
            end
        end else begin
            state_r <= state_r;
            ext_r   <= ext_r;
        end
    end

    // Next-state decode on each accepted byte.
    always_comb begin
        state_nxt_s = state_r;
        if (byte_valid_s) begin
            case (state_r)
                DEC_IDLE: begin
                    if (rx_byte_s == PS2_CODE_EXT) begin
                        state_nxt_s = DEC_EXT;
                    end else if (rx_byte_s == PS2_CODE_BRK) begin
                        state_nxt_s = DEC_BRK;
                    end else begin
                        state_nxt_s = DEC_IDLE;
                    end
                end
                DEC_EXT: begin
                    if (rx_byte_s == PS2_CODE_BRK) begin
                        state_nxt_s = DEC_BRK;
                    end else begin
                        state_nxt_s = DEC_IDLE;
                    end
                end
                DEC_BRK: state_nxt_s = DEC_IDLE;
                default: state_nxt_s = DEC_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // An event is emitted exactly when a byte returns the decoder to IDLE.
    always_comb begin
        evt_s.ext  = ext_r;
        evt_s.brk  = (state_r == DEC_BRK);
        evt_s.code = rx_byte_s;
        evt_push_s = byte_valid_s && (state_nxt_s == DEC_IDLE);
    end

    // Modifier tracking follows pushed make/break events.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_held_r <= 1'b0;
            ctrl_held_r  <= 1'b0;
        end else begin
            if (evt_push_s && !evt_s.ext &&
                (evt_s.code == PS2_LSHIFT || evt_s.code == PS2_RSHIFT)) begin
                shift_held_r <= !evt_s.brk;
            end
            if (evt_push_s && evt_s.code == PS2_CTRL) begin
                ctrl_held_r <= !evt_s.brk;
            end
        end
    end

    assign shift_held = shift_held_r;
    assign ctrl_held  = ctrl_held_r;
`else
    assign evt_push_s = byte_valid_s;
    assign evt_s      = {2'b00, rx_byte_s};
    assign shift_held = 1'b0;
    assign ctrl_held  = 1'b0;
`endif

    key_evt_t      mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          overflow_r;
    logic          full_s;
    logic          pop_s;
    logic          wr_s;

    assign full_s = (count_r == CW'(FIFO_DEPTH));
    assign pop_s  = rd_en && (count_r != '0);
    assign wr_s   = evt_push_s && (!full_s || pop_s);

    // Event storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= evt_s;
        end
    end

    // Pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (evt_push_s && full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign key_valid  = (count_r != '0);
    assign key_data   = key_valid ? mem_r[rd_ptr_r] : 10'd0;
    assign fifo_count = count_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_ps2_kbd_rx_fifo.sv
// Directed self-checking bench for ps2_kbd_rx_fifo; expectations follow PS2_KBD_DECODE_EN.
module tb_ps2_kbd_rx_fifo;

    localparam int HALF = 8;
    localparam int TO   = 300;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rd_en;
    logic       key_valid;
    logic [9:0] key_data;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       frame_err;
    logic       shift_held;
    logic       ctrl_held;

    int   total   = 0;
    int   bad     = 0;
    int   err_cnt = 0;
    int   e0;
    logic kv_at2;
    logic kv_at3;
    logic [10:0] fb;

    ps2_kbd_rx_fifo #(
        .FIFO_DEPTH (8),
        .SYNC_STAGES(3),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en),
        .key_valid (key_valid),
        .key_data  (key_data),
        .fifo_count(fifo_count),
        .overflow  (overflow),
        .frame_err (frame_err),
        .shift_held(shift_held),
        .ctrl_held (ctrl_held)
    );

    always #5 clk = ~clk;

    // Counts cycles with frame_err high; one error must add exactly one.
    always @(posedge clk) begin
        if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] good_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [10:0] bits, input int nbits, input bit pop_at_write);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk) ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) begin
                @(posedge clk);
                @(posedge clk);
                #1 kv_at2 = key_valid;
                if (pop_at_write) begin
                    @(negedge clk) rd_en = 1'b1;
                end
                @(posedge clk);
                #1 kv_at3 = key_valid;
                if (pop_at_write) begin
                    @(negedge clk) rd_en = 1'b0;
                end
            end
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        @(negedge clk) ps2_data = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(good_frame(b), 11, 1'b0);
    endtask

    task automatic pop_expect(input string tag, input logic [9:0] exp);
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, key_valid}, 32'd1);
        check({tag, "_data"}, {22'd0, key_data}, {22'd0, exp});
        rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_valid", {31'd0, key_valid}, 32'd0);
        check("rst_data", {22'd0, key_data}, 32'd0);
        check("rst_count", {28'd0, fifo_count}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_shift", {31'd0, shift_held}, 32'd0);
        check("rst_ctrl", {31'd0, ctrl_held}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // single make code and write latency
        send_frame(good_frame(8'h1C), 11, 1'b0);
        check("lat_early", {31'd0, kv_at2}, 32'd0);
        check("lat_valid", {31'd0, kv_at3}, 32'd1);
        check("make_data", {22'd0, key_data}, 32'h01C);
        check("make_count", {28'd0, fifo_count}, 32'd1);
        pop_expect("make_pop", 10'h01C);
        check("make_empty", {28'd0, fifo_count}, 32'd0);

        // break sequence
        send_byte(8'hF0); send_byte(8'h1C);
`ifdef PS2_KBD_DECODE_EN
        check("brk_count", {28'd0, fifo_count}, 32'd1);
        pop_expect("brk_pop", 10'h11C);
`else
        check("brk_count", {28'd0, fifo_count}, 32'd2);
        pop_expect("brk_pop0", 10'h0F0);
        pop_expect("brk_pop1", 10'h01C);
`endif

        // extended break
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
`ifdef PS2_KBD_DECODE_EN
        check("ext_count", {28'd0, fifo_count}, 32'd1);
        pop_expect("ext_pop", 10'h375);
`else
        check("ext_count", {28'd0, fifo_count}, 32'd3);
        pop_expect("ext_pop0", 10'h0E0);
        pop_expect("ext_pop1", 10'h0F0);
        pop_expect("ext_pop2", 10'h075);
`endif

        // shift tracking
        send_byte(8'h12);
`ifdef PS2_KBD_DECODE_EN
        check("shift_set", {31'd0, shift_held}, 32'd1);
`else
        check("shift_set", {31'd0, shift_held}, 32'd0);
`endif
        send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h12);
        check("shift_clr", {31'd0, shift_held}, 32'd0);
`ifdef PS2_KBD_DECODE_EN
        check("shift_count", {28'd0, fifo_count}, 32'd3);
        pop_expect("sh_pop0", 10'h012);
        pop_expect("sh_pop1", 10'h01C);
        pop_expect("sh_pop2", 10'h112);
`else
        check("shift_count", {28'd0, fifo_count}, 32'd4);
        pop_expect("sh_pop0", 10'h012);
        pop_expect("sh_pop1", 10'h01C);
        pop_expect("sh_pop2", 10'h0F0);
        pop_expect("sh_pop3", 10'h012);
`endif

        // right ctrl (extended) make then plain ctrl break
        send_byte(8'hE0); send_byte(8'h14);
`ifdef PS2_KBD_DECODE_EN
        check("ctrl_set", {31'd0, ctrl_held}, 32'd1);
`else
        check("ctrl_set", {31'd0, ctrl_held}, 32'd0);
`endif
        send_byte(8'hF0); send_byte(8'h14);
        check("ctrl_clr", {31'd0, ctrl_held}, 32'd0);
`ifdef PS2_KBD_DECODE_EN
        pop_expect("ct_pop0", 10'h214);
        pop_expect("ct_pop1", 10'h114);
`else
        pop_expect("ct_pop0", 10'h0E0);
        pop_expect("ct_pop1", 10'h014);
        pop_expect("ct_pop2", 10'h0F0);
        pop_expect("ct_pop3", 10'h014);
`endif
        check("ct_empty", {28'd0, fifo_count}, 32'd0);

        // bad parity then bad stop
        e0 = err_cnt;
        fb = good_frame(8'h1C);
        fb[9] = ~fb[9];
        send_frame(fb, 11, 1'b0);
        fb = good_frame(8'h1C);
        fb[10] = 1'b0;
        send_frame(fb, 11, 1'b0);
        check("ferr_pulses", err_cnt - e0, 32'd2);
        check("ferr_empty", {28'd0, fifo_count}, 32'd0);

        // overflow: nine pushes into eight entries, then full push with pop
        for (int b = 1; b <= 9; b++) send_byte(8'(b));
        check("ovf_count", {28'd0, fifo_count}, 32'd8);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        send_frame(good_frame(8'h0A), 11, 1'b1);
        check("fullpp_count", {28'd0, fifo_count}, 32'd8);
        for (int b = 2; b <= 8; b++) pop_expect("ovf_pop", 10'(b));
        pop_expect("ovf_pop_last", 10'h00A);
        check("ovf_drained", {31'd0, key_valid}, 32'd0);
        @(negedge clk) rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
        check("empty_rd", {28'd0, fifo_count}, 32'd0);

        // reset clears overflow; partial frame times out
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ovf_clr", {31'd0, overflow}, 32'd0);
        e0 = err_cnt;
        send_frame(good_frame(8'h2B), 5, 1'b0);
        repeat (TO + 50) @(negedge clk);
        check("timeout_err", err_cnt - e0, 32'd1);
        send_byte(8'h2B);
        check("post_to_count", {28'd0, fifo_count}, 32'd1);
        pop_expect("post_to_pop", 10'h02B);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
